seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive-side counterpart of the hex-to-seven-segment display path: it watches the multiplexed anode/cathode lines driven to the 8-digit display and reconstructs the displayed hex values. Each anode strobe is debounced for a programmable settle time. The active-low cathode pattern is then decoded back to a nibble and stored per digit position. A pulse is raised once all eight digits of a scan frame have been captured. The block is used as an on-board monitor and as a self-check for the display driver.

## Interface
- SETTLE, 4, consecutive stable cycles required before capture (≥1; counter width $clog2(SETTLE+1))
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- anode  in  8  digit enables, active-low; bit i low selects digit i
- cathode  in  8  segment lines, active-low; bit7 = dp, bits6..0 = g..a
- err_clr  in  1  synchronous clear of pattern_err
- digits  out  32  decoded nibbles; digits[4i+3:4i] = digit i
- dp  out  8  captured decimal point per digit (1 = lit)
- blank_mask  out  8  bit i = 1 when digit i was last captured all-segments-off
- frame_valid  out  1  one-cycle pulse, all 8 positions captured since last pulse
- pattern_err  out  1  sticky, an undecodable pattern was captured

## Operation
- Input registers a_q, c_q load anode and cathode every cycle; reset value 8'hFF for both.
- A valid selection is anode with exactly one bit low; any other anode value is invalid.
- States:
  - IDLE: no valid selection.
  - SETTLE: counting stable cycles, cnt.
  - HOLD: the current selection has been captured; wait for a change.
- Each edge, the incoming {anode, cathode} is compared with {a_q, c_q}:
  - Differs, incoming selection valid: cnt←1, go to SETTLE.
  - Differs, incoming selection invalid: go to IDLE.
  - Equal, in SETTLE, cnt<SETTLE: cnt←cnt+1.
  - Equal, in SETTLE, cnt==SETTLE: capture, go to HOLD.
  - Equal, in IDLE or HOLD: no change.
- Capture uses digit index i (position of the low bit of a_q) and pattern p = c_q[6:0]:
  - p decodes as 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - Decodable p: write the nibble, clear blank_mask[i], set seen[i].
  - p = 7F: write nibble 0, set blank_mask[i], set seen[i].
  - Any other p: digit i, blank_mask[i] and seen[i] are unchanged; set pattern_err.
  - dp[i] ← ~c_q[7] on every capture, including undecodable ones.
- Frame tracking uses the internal register seen[7:0]:
  - If a capture makes seen == 8'hFF, frame_valid is 1 for the following cycle and seen ← 0 on that same edge.
  - Recapturing a position before the frame completes overwrites the digit; seen is unchanged.
- pattern_err: cleared by err_clr; a set and err_clr on the same edge leaves it 1 (set wins).

## Timing
- Reset values: digits 0, dp 0, blank_mask 0, frame_valid 0, pattern_err 0, seen 0, cnt 0, state IDLE.
- Reset is asynchronous; asserting it mid-SETTLE or mid-HOLD returns everything to reset values immediately. After release, the current inputs are treated as a change.
- Latency: inputs change before edge 1 and are then held. Capture happens on edge SETTLE+1, and digits, dp, blank_mask and pattern_err are updated after that edge.
- A change on either bus during SETTLE restarts the count at 1; no partial capture occurs.
- At most one capture per selection; a selection held indefinitely captures once.
- A change while in HOLD, including a cathode-only change on the same digit, starts a new SETTLE and later a new capture.
- frame_valid is never high for two consecutive cycles; with SETTLE ≥ 1 the minimum spacing is 8·(SETTLE+1) cycles.

## Test plan
- Single digit: SETTLE=4, anode=FE, cathode=C0 held for 10 cycles. Required: digits[3:0]=0 after edge 5, exactly one capture, frame_valid stays 0, blank_mask[0]=0.
- Full frame: digit i held at pattern(i+1) for 6 cycles each, i=0..7, with cathode bit7=0 on digit 3. Required: digits=32'h87654321, dp=8'h08, a single frame_valid pulse one cycle after the eighth capture, seen cleared.
- Glitch restart: anode=FD, cathode 92 changes to 99 at cnt=3. Required: no capture at the original edge 5; digits[7:4]=4 exactly SETTLE+1 edges after the change.
- Invalid inputs:
  - anode=FC, and separately anode=FF, for 20 cycles: no capture.
  - cathode=55 on digit 2: pattern_err=1, digits[11:8] unchanged.
  - err_clr pulsed alone: pattern_err=0.
  - err_clr coincident with a new invalid capture: pattern_err stays 1.
- Blank and overwrite: digit 5 captured with cathode FF, then with 86. Required: blank_mask[5]=1 then 0, digits[23:20]=0 then E, no extra frame_valid.
- Reset mid-operation: reset low at cnt=2 during a partially complete frame. Required: all outputs 0 at once. After release, a full frame is required before frame_valid pulses.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - reconstructs displayed hex digits from multiplexed 7-seg anode/cathode lines
// Each anode strobe must hold steady for SETTLE cycles before its cathode pattern is decoded and stored.
module seg7_scan_decoder #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode,
  input  logic [7:0]  cathode,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  blank_mask,
  output logic        frame_valid,
  output logic        pattern_err
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    a_q;
  logic [7:0]    c_q;
  logic [7:0]    seen;

  logic          in_changed;
  logic          in_valid;
  logic          capture;
  logic [2:0]    idx;
  logic          dec_ok;
  logic [3:0]    dec_nib;
  logic          is_blank;
  logic [7:0]    seen_upd;

  // Segment patterns are active-low g..a; the table index is the nibble value.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    case (p)
      7'h40:   return {1'b1, 4'h0};
      7'h79:   return {1'b1, 4'h1};
      7'h24:   return {1'b1, 4'h2};
      7'h30:   return {1'b1, 4'h3};
      7'h19:   return {1'b1, 4'h4};
      7'h12:   return {1'b1, 4'h5};
      7'h02:   return {1'b1, 4'h6};
      7'h78:   return {1'b1, 4'h7};
      7'h00:   return {1'b1, 4'h8};
      7'h18:   return {1'b1, 4'h9};
      7'h08:   return {1'b1, 4'hA};
      7'h03:   return {1'b1, 4'hB};
      7'h46:   return {1'b1, 4'hC};
      7'h21:   return {1'b1, 4'hD};
      7'h06:   return {1'b1, 4'hE};
      7'h0E:   return {1'b1, 4'hF};
      default: return 5'h00;
    endcase
  endfunction

  always_comb begin
    in_changed = ({anode, cathode} != {a_q, c_q});
    in_valid   = $onehot(~anode);
    capture    = (state == S_SETTLE) && !in_changed && (cnt == SETTLE_C);
    {dec_ok, dec_nib} = decode_seg(c_q[6:0]);
    is_blank   = (c_q[6:0] == 7'h7F);
    idx        = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!a_q[i]) idx = 3'(i);
    end
    seen_upd      = seen;
    seen_upd[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_q         <= 8'hFF;
      c_q         <= 8'hFF;
      seen        <= 8'h00;
      digits      <= 32'h0;
      dp          <= 8'h00;
      blank_mask  <= 8'h00;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      a_q         <= anode;
      c_q         <= cathode;
      frame_valid <= 1'b0;

      if (in_changed) begin
        if (in_valid) begin
          cnt   <= CW'(1);
          state <= S_SETTLE;
        end else begin
          state <= S_IDLE;
        end
      end else if (state == S_SETTLE) begin
        if (cnt < SETTLE_C) cnt <= cnt + CW'(1);
        else                state <= S_HOLD;
      end

      if (capture) begin
        dp[idx] <= ~c_q[7];
        if (dec_ok || is_blank) begin
          digits[{idx, 2'b00} +: 4] <= dec_ok ? dec_nib : 4'h0;
          blank_mask[idx]           <= is_blank;
          // Completing a frame clears seen on the same edge so the next frame starts fresh.
          if (seen_upd == 8'hFF) begin
            seen        <= 8'h00;
            frame_valid <= 1'b1;
          end else begin
            seen <= seen_upd;
          end
        end
      end

      pattern_err <= (capture && !dec_ok && !is_blank) || (pattern_err && !err_clr);
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
// Stimulus pushes a per-edge expected output snapshot from a stable-run model; the monitor pops and compares.
module tb_seg7_scan_decoder;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  anode = 8'hFF;
  logic [7:0]  cathode = 8'hFF;
  logic        err_clr = 1'b0;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  blank_mask;
  logic        frame_valid;
  logic        pattern_err;

  seg7_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .anode       (anode),
    .cathode     (cathode),
    .err_clr     (err_clr),
    .digits      (digits),
    .dp          (dp),
    .blank_mask  (blank_mask),
    .frame_valid (frame_valid),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  typedef logic [49:0] snap_t;
  snap_t exp_q[$];

  int checks = 0;
  int failures = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic [3:0]  m_dig [8];
  logic [7:0]  m_dp, m_blank, m_seen;
  logic        m_fv, m_err;
  logic [15:0] m_prev;
  int          m_run;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic snap_t model_snap();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) d[i*4 +: 4] = m_dig[i];
    return {d, m_dp, m_blank, m_fv, m_err};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
    m_dp = 8'h00; m_blank = 8'h00; m_seen = 8'h00;
    m_fv = 1'b0; m_err = 1'b0;
    m_prev = 16'hFFFF; m_run = 0;
  endtask

  // A selection is captured on the edge where it has been presented unchanged for SETTLE+1 edges.
  task automatic model_edge(input logic [7:0] an, input logic [7:0] ca, input logic ec);
    logic err_set;
    int   sel, found;
    err_set = 1'b0;
    m_fv = 1'b0;
    if ({an, ca} != m_prev) m_run = 1;
    else if (m_run < 100000) m_run++;
    m_prev = {an, ca};
    if (m_run == SETTLE + 1 && $countones(~an) == 1) begin
      sel = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) sel = i;
      found = -1;
      for (int k = 0; k < 16; k++) if (seg_tab[k] == ca[6:0]) found = k;
      m_dp[sel] = ~ca[7];
      if (found >= 0 || ca[6:0] == 7'h7F) begin
        m_dig[sel]   = (found >= 0) ? 4'(found) : 4'h0;
        m_blank[sel] = (found < 0);
        m_seen[sel]  = 1'b1;
        if (m_seen == 8'hFF) begin
          m_fv = 1'b1;
          m_seen = 8'h00;
        end
      end else begin
        err_set = 1'b1;
      end
    end
    m_err = err_set | (m_err & ~ec);
  endtask

  task automatic step(input logic [7:0] an, input logic [7:0] ca, input logic ec = 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    anode = an;
    cathode = ca;
    err_clr = ec;
    model_edge(an, ca, ec);
    exp_q.push_back(model_snap());
  endtask

  task automatic hold(input logic [7:0] an, input logic [7:0] ca, input int n);
    repeat (n) step(an, ca);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    err_clr = 1'b0;
    #1;
    check("reset_immediate", {digits, dp, blank_mask, frame_valid, pattern_err}, 64'h0);
    model_reset();
    exp_q.push_back(model_snap());
    repeat (n - 1) begin
      @(negedge clk);
      exp_q.push_back(model_snap());
    end
  endtask

  task automatic peek();
    @(posedge clk);
    #2;
  endtask

  task automatic full_frame();
    logic [7:0] an;
    for (int i = 0; i < 8; i++) begin
      an = ~(8'h01 << i);
      hold(an, {(i != 3), seg_tab[i+1]}, 6);
    end
  endtask

  // Monitor: one expected snapshot per active edge
  initial begin
    snap_t e;
    logic  prev_fv;
    prev_fv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", {digits, dp, blank_mask, frame_valid, pattern_err}, e);
        check("fv_back_to_back", prev_fv & frame_valid, 1'b0);
      end
      prev_fv = frame_valid;
    end
  end

  initial begin
    logic [7:0] an, ca;
    int w;
    model_reset();
    do_reset(3);

    hold(8'hFE, 8'hC0, 10);
    peek();
    check("single_digit0", digits[3:0], 4'h0);
    check("single_fv", frame_valid, 1'b0);
    check("single_blank0", blank_mask[0], 1'b0);

    full_frame();
    peek();
    check("frame_digits", digits, 32'h87654321);
    check("frame_dp", dp, 8'h08);

    hold(8'hFD, 8'h92, 3);
    hold(8'hFD, 8'h99, 4);
    peek();
    check("glitch_no_early", digits[7:4], 4'h2);
    step(8'hFD, 8'h99);
    peek();
    check("glitch_capture", digits[7:4], 4'h4);

    hold(8'hFC, 8'hC0, 20);
    hold(8'hFF, 8'hC0, 20);
    peek();
    check("invalid_sel", digits, 32'h87654341);

    hold(8'hFB, 8'h55, 6);
    peek();
    check("bad_pattern_err", pattern_err, 1'b1);
    check("bad_pattern_digit", digits[11:8], 4'h3);
    step(8'hFB, 8'h55, 1'b1);
    peek();
    check("err_clr_alone", pattern_err, 1'b0);
    hold(8'hFB, 8'h56, 4);
    step(8'hFB, 8'h56, 1'b1);
    peek();
    check("err_set_wins", pattern_err, 1'b1);

    hold(8'hDF, 8'hFF, 6);
    peek();
    check("blank_set", blank_mask[5], 1'b1);
    check("blank_digit", digits[23:20], 4'h0);
    hold(8'hDF, 8'h86, 6);
    peek();
    check("overwrite_blank", blank_mask[5], 1'b0);
    check("overwrite_digit", digits[23:20], 4'hE);

    hold(8'hFE, 8'hF9, 6);
    hold(8'hFD, 8'hA4, 6);
    hold(8'hFB, 8'hB0, 6);
    hold(8'hF7, 8'h99, 2);
    do_reset(2);
    full_frame();
    peek();
    check("post_reset_digits", digits, 32'h87654321);
    check("post_reset_dp", dp, 8'h08);

    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 9) == 0) begin
        an = 8'($urandom());
        if ($countones(~an) == 1) an = 8'hFF;
      end else begin
        an = ~(8'h01 << $urandom_range(0, 7));
      end
      case ($urandom_range(0, 9))
        0:       ca = {1'($urandom()), 7'h7F};
        1:       ca = 8'($urandom());
        default: ca = {1'($urandom()), seg_tab[$urandom_range(0, 15)]};
      endcase
      repeat ($urandom_range(1, 8)) step(an, ca, ($urandom_range(0, 15) == 0));
    end

    w = 0;
    while (exp_q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    check("scoreboard_drain", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
